// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C target state encoding, ACK levels and bit-count width
package i2c_pkg;

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_ADDR      = 4'd1;
    localparam logic [3:0] S_ADDR_ACK  = 4'd2;
    localparam logic [3:0] S_REG       = 4'd3;
    localparam logic [3:0] S_REG_ACK   = 4'd4;
    localparam logic [3:0] S_WDATA     = 4'd5;
    localparam logic [3:0] S_WDATA_ACK = 4'd6;
    localparam logic [3:0] S_RDATA     = 4'd7;
    localparam logic [3:0] S_RDATA_ACK = 4'd8;
    localparam logic [3:0] S_IGNORE    = 4'd9;

    typedef enum logic [3:0] {
        IDLE      = S_IDLE,
        ADDR      = S_ADDR,
        ADDR_ACK  = S_ADDR_ACK,
        REG       = S_REG,
        REG_ACK   = S_REG_ACK,
        WDATA     = S_WDATA,
        WDATA_ACK = S_WDATA_ACK,
        RDATA     = S_RDATA,
        RDATA_ACK = S_RDATA_ACK,
        IGNORE    = S_IGNORE
    } i2c_state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    // Counts 0..8 so the falling edge after the 8th bit can be recognised.
    localparam int BIT_CNT_W = 4;
    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(7);
    localparam logic [BIT_CNT_W-1:0] BIT_DONE = BIT_CNT_W'(8);

endpackage

// File: rtl/i2c_target_regif_if.sv
// rtl/i2c_target_regif_if.sv - synchronous register port between the I2C target and the register file
interface i2c_target_regif_if;
    logic [7:0] reg_addr;
    logic       reg_wr_en;
    logic [7:0] reg_wr_data;
    logic       reg_rd_en;
    logic [7:0] reg_rd_data;
    logic       busy;

    modport master (
        output reg_addr, reg_wr_en, reg_wr_data, reg_rd_en, busy,
        input  reg_rd_data
    );

    modport slave (
        input  reg_addr, reg_wr_en, reg_wr_data, reg_rd_en, busy,
        output reg_rd_data
    );
endinterface

// File: rtl/i2c_line_sync.sv
// rtl/i2c_line_sync.sv - SCL/SDA synchronizers with registered edge, START and STOP pulses
module i2c_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_pin,
    input  logic sda_pin,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_bit
);
    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_q;
    logic       sda_q;

    // Idle bus is high; resetting to 1 avoids a false edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync  <= 2'b11;
            sda_sync  <= 2'b11;
            scl_q     <= 1'b1;
            sda_q     <= 1'b1;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            sda_bit   <= 1'b1;
        end else begin
            scl_sync  <= {scl_sync[0], scl_pin};
            sda_sync  <= {sda_sync[0], sda_pin};
            scl_q     <= scl_sync[1];
            sda_q     <= sda_sync[1];
            scl_rise  <= scl_sync[1] & ~scl_q;
            scl_fall  <= ~scl_sync[1] & scl_q;
            start_det <= scl_sync[1] & scl_q & sda_q & ~sda_sync[1];
            stop_det  <= scl_sync[1] & scl_q & ~sda_q & sda_sync[1];
            sda_bit   <= sda_sync[1];
        end
    end
endmodule

// File: rtl/i2c_target_regif.sv
// rtl/i2c_target_regif.sv - I2C target with 8-bit register pointer and synchronous register port
module i2c_target_regif
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'h48
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i2c_sclk,
    inout  wire                i2c_sdat,
    i2c_target_regif_if.master regs
);
    logic scl_rise, scl_fall, start_det, stop_det, sda_bit;

    i2c_line_sync u_line_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_pin   (i2c_sclk),
        .sda_pin   (i2c_sdat),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_bit   (sda_bit)
    );

    i2c_state_t           state;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [6:0]           rx_sr;
    logic [7:0]           rx_byte;
    logic [7:0]           tx_sr;
    logic [7:0]           reg_addr;
    logic [7:0]           reg_wr_data;
    logic                 reg_wr_en, reg_rd_en, rd_next, rd_load, rw, busy, sda_oe;

    assign rx_byte  = {rx_sr, sda_bit};
    assign i2c_sdat = sda_oe ? 1'b0 : 1'bz;

    assign regs.reg_addr    = reg_addr;
    assign regs.reg_wr_en   = reg_wr_en;
    assign regs.reg_wr_data = reg_wr_data;
    assign regs.reg_rd_en   = reg_rd_en;
    assign regs.busy        = busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            rx_sr       <= '0;
            tx_sr       <= '0;
            rw          <= 1'b0;
            reg_addr    <= '0;
            reg_wr_data <= '0;
            reg_wr_en   <= 1'b0;
            reg_rd_en   <= 1'b0;
            rd_next     <= 1'b0;
            rd_load     <= 1'b0;
            busy        <= 1'b0;
            sda_oe      <= 1'b0;
        end else begin
            reg_wr_en <= 1'b0;
            reg_rd_en <= rd_next;
            rd_next   <= 1'b0;
            rd_load   <= reg_rd_en;
            // Read data is valid the cycle after the request.
            if (rd_load) tx_sr <= regs.reg_rd_data;
            if (reg_wr_en) reg_addr <= reg_addr + 8'd1;

            if (start_det || stop_det) begin
                state   <= start_det ? ADDR : IDLE;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    ADDR, REG, WDATA: begin
                        if (scl_rise) begin
                            rx_sr   <= rx_byte[6:0];
                            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                            if (bit_cnt == BIT_LAST) begin
                                if (state == ADDR) begin
                                    rw <= sda_bit;
                                    if (rx_byte[7:1] != DEV_ADDR) state <= IGNORE;
                                end
                                if (state == REG) reg_addr <= rx_byte;
                                if (state == WDATA) begin
                                    reg_wr_en   <= 1'b1;
                                    reg_wr_data <= rx_byte;
                                end
                            end
                        end else if (scl_fall && bit_cnt == BIT_DONE) begin
                            bit_cnt <= '0;
                            sda_oe  <= 1'b1;
                            if (state == ADDR) begin
                                state     <= ADDR_ACK;
                                busy      <= 1'b1;
                                reg_rd_en <= rw;
                            end else if (state == REG) begin
                                state <= REG_ACK;
                            end else begin
                                state <= WDATA_ACK;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            if (rw) begin
                                state  <= RDATA;
                                sda_oe <= ~tx_sr[7];
                                tx_sr  <= {tx_sr[6:0], 1'b0};
                            end else begin
                                state  <= REG;
                                sda_oe <= 1'b0;
                            end
                        end
                    end
                    REG_ACK, WDATA_ACK: begin
                        if (scl_fall) begin
                            state  <= WDATA;
                            sda_oe <= 1'b0;
                        end
                    end
                    RDATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                        end else if (scl_fall) begin
                            if (bit_cnt == BIT_DONE) begin
                                state   <= RDATA_ACK;
                                bit_cnt <= '0;
                                sda_oe  <= 1'b0;
                            end else begin
                                sda_oe <= ~tx_sr[7];
                                tx_sr  <= {tx_sr[6:0], 1'b0};
                            end
                        end
                    end
                    RDATA_ACK: begin
                        if (scl_rise) begin
                            if (sda_bit == I2C_NACK) begin
                                state <= IGNORE;
                            end else begin
                                // Bump first so the read request sees the new pointer.
                                reg_addr <= reg_addr + 8'd1;
                                rd_next  <= 1'b1;
                            end
                        end else if (scl_fall) begin
                            state  <= RDATA;
                            sda_oe <= ~tx_sr[7];
                            tx_sr  <= {tx_sr[6:0], 1'b0};
                        end
                    end
                    default: sda_oe <= 1'b0;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_target_regif.sv
// tb/tb_i2c_target_regif.sv - self-checking bench: bus controller model, register file and strobe scoreboard
module tb_i2c_target_regif;
    import i2c_pkg::*;

    localparam int Q = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic scl = 1'b1;
    logic tb_sda_low = 1'b0;
    wire  sda;

    assign sda = tb_sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_target_regif_if regs ();

    i2c_target_regif #(.DEV_ADDR(7'h48)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i2c_sclk (scl),
        .i2c_sdat (sda),
        .regs     (regs)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic       is_wr;
        logic [7:0] addr;
        logic [7:0] data;
    } sb_t;

    typedef struct {
        logic [7:0] dev;
        logic [7:0] ra;
        logic [7:0] wd;
        logic       ack;
        logic [7:0] ptr;
    } vec_t;

    sb_t        exp_q[$];
    vec_t       vecs[6];
    logic [7:0] mem[256];
    int         checks = 0;
    int         failures = 0;
    int         dut_low_cnt = 0;

    // Register file: read data appears one clock after the request.
    always @(posedge clk) begin
        if (regs.reg_wr_en) mem[regs.reg_addr] <= regs.reg_wr_data;
        if (regs.reg_rd_en) regs.reg_rd_data <= mem[regs.reg_addr];
    end

    always @(negedge clk) begin
        if (sda === 1'b0 && !tb_sda_low) dut_low_cnt++;
    end

    always @(negedge clk) begin
        if (rst_n && (regs.reg_wr_en || regs.reg_rd_en)) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL strobe_unexpected wr=%0b rd=%0b addr=%02h data=%02h",
                         regs.reg_wr_en, regs.reg_rd_en, regs.reg_addr, regs.reg_wr_data);
            end else begin
                sb_t e;
                e = exp_q.pop_front();
                if ((regs.reg_wr_en && regs.reg_rd_en) || e.is_wr != regs.reg_wr_en ||
                    e.addr != regs.reg_addr || (e.is_wr && e.data != regs.reg_wr_data)) begin
                    failures++;
                    $display("FAIL strobe got wr=%0b rd=%0b addr=%02h data=%02h exp wr=%0b addr=%02h data=%02h",
                             regs.reg_wr_en, regs.reg_rd_en, regs.reg_addr, regs.reg_wr_data,
                             e.is_wr, e.addr, e.data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic sb_empty(input string name);
        chk({name, "_missing_strobes"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic push(input logic is_wr, input logic [7:0] addr, input logic [7:0] data);
        sb_t e;
        e.is_wr = is_wr;
        e.addr  = addr;
        e.data  = data;
        exp_q.push_back(e);
    endtask

    task automatic wait_q();
        repeat (Q) @(posedge clk);
        #2;
    endtask

    task automatic bit_xfer(input logic b, output logic s);
        tb_sda_low = ~b;
        wait_q();
        scl = 1'b1;
        wait_q();
        @(negedge clk);
        s = sda;
        wait_q();
        scl = 1'b0;
        wait_q();
    endtask

    task automatic i2c_start();
        tb_sda_low = 1'b0;
        wait_q();
        scl = 1'b1;
        wait_q();
        tb_sda_low = 1'b1;
        wait_q();
        scl = 1'b0;
        wait_q();
    endtask

    task automatic i2c_stop();
        tb_sda_low = 1'b1;
        wait_q();
        scl = 1'b1;
        wait_q();
        tb_sda_low = 1'b0;
        wait_q();
        wait_q();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], s);
        bit_xfer(1'b1, ack);
    endtask

    task automatic read_byte(input logic ctl_ack, output logic [7:0] d, output logic line);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, s);
            d[i] = s;
        end
        bit_xfer(ctl_ack ? I2C_ACK : I2C_NACK, line);
    endtask

    // START, address+write, pointer byte, then repeated START and address+read.
    task automatic read_setup(input logic [7:0] ptr, input string name);
        logic a;
        i2c_start();
        write_byte(8'h90, a);
        chk({name, "_waddr_ack"}, a, I2C_ACK);
        write_byte(ptr, a);
        chk({name, "_ptr_ack"}, a, I2C_ACK);
        i2c_start();
        push(1'b0, ptr, 8'h00);
        write_byte(8'h91, a);
        chk({name, "_raddr_ack"}, a, I2C_ACK);
    endtask

    initial begin
        logic       a, line;
        logic [7:0] d;
        int         low0;

        vecs[0] = '{8'h90, 8'h05, 8'hA5, I2C_ACK,  8'h06};
        vecs[1] = '{8'h90, 8'hFF, 8'hC3, I2C_ACK,  8'h00};
        vecs[2] = '{8'hA0, 8'h33, 8'h44, I2C_NACK, 8'h00};
        vecs[3] = '{8'h90, 8'h00, 8'h3C, I2C_ACK,  8'h01};
        vecs[4] = '{8'h92, 8'h12, 8'h34, I2C_NACK, 8'h01};
        vecs[5] = '{8'h90, 8'h01, 8'h77, I2C_ACK,  8'h02};

        repeat (5) @(negedge clk);
        chk("rst_reg_addr", regs.reg_addr, 8'h00);
        chk("rst_wr_en", regs.reg_wr_en, 1'b0);
        chk("rst_rd_en", regs.reg_rd_en, 1'b0);
        chk("rst_wr_data", regs.reg_wr_data, 8'h00);
        chk("rst_busy", regs.busy, 1'b0);
        chk("rst_sda", sda, 1'b1);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            low0 = dut_low_cnt;
            i2c_start();
            write_byte(vecs[i].dev, a);
            chk($sformatf("v%0d_addr_ack", i), a, vecs[i].ack);
            if (vecs[i].ack == I2C_ACK) begin
                chk($sformatf("v%0d_busy", i), regs.busy, 1'b1);
                write_byte(vecs[i].ra, a);
                chk($sformatf("v%0d_reg_ack", i), a, I2C_ACK);
                push(1'b1, vecs[i].ra, vecs[i].wd);
                write_byte(vecs[i].wd, a);
                chk($sformatf("v%0d_data_ack", i), a, I2C_ACK);
            end else begin
                chk($sformatf("v%0d_busy_ignored", i), regs.busy, 1'b0);
                chk($sformatf("v%0d_sda_driven_cycles", i), dut_low_cnt - low0, 0);
            end
            i2c_stop();
            chk($sformatf("v%0d_busy_after_stop", i), regs.busy, 1'b0);
            chk($sformatf("v%0d_ptr", i), regs.reg_addr, vecs[i].ptr);
            sb_empty($sformatf("v%0d", i));
        end

        read_setup(8'h00, "rd1");
        read_byte(1'b0, d, line);
        chk("rd1_byte", d, 8'h3C);
        chk("rd1_sda_released", line, 1'b1);
        i2c_stop();
        chk("rd1_ptr", regs.reg_addr, 8'h00);
        sb_empty("rd1");

        read_setup(8'h00, "burst");
        push(1'b0, 8'h01, 8'h00);
        read_byte(1'b1, d, line);
        chk("burst_byte0", d, 8'h3C);
        read_byte(1'b0, d, line);
        chk("burst_byte1", d, 8'h77);
        i2c_stop();
        chk("burst_ptr", regs.reg_addr, 8'h01);
        sb_empty("burst");

        read_setup(8'hFF, "wrap");
        push(1'b0, 8'h00, 8'h00);
        read_byte(1'b1, d, line);
        chk("wrap_byte0", d, 8'hC3);
        read_byte(1'b0, d, line);
        chk("wrap_byte1", d, 8'h3C);
        i2c_stop();
        chk("wrap_ptr", regs.reg_addr, 8'h00);
        sb_empty("wrap");

        i2c_start();
        push(1'b0, 8'h00, 8'h00);
        write_byte(8'h91, a);
        chk("persist_addr_ack", a, I2C_ACK);
        read_byte(1'b0, d, line);
        chk("persist_byte", d, 8'h3C);
        i2c_stop();
        sb_empty("persist");

        i2c_start();
        write_byte(8'h90, a);
        write_byte(8'h20, a);
        chk("partial_ptr_ack", a, I2C_ACK);
        for (int i = 0; i < 4; i++) bit_xfer(1'b1, line);
        i2c_stop();
        chk("partial_ptr", regs.reg_addr, 8'h20);
        chk("partial_fsm_idle", 32'(dut.state), 32'(S_IDLE));
        chk("partial_busy", regs.busy, 1'b0);
        sb_empty("partial");

        read_setup(8'h01, "rstmid");
        chk("rstmid_sda_bit0_low", sda, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rstmid_sda_released", sda, 1'b1);
        chk("rstmid_reg_addr", regs.reg_addr, 8'h00);
        chk("rstmid_wr_data", regs.reg_wr_data, 8'h00);
        chk("rstmid_busy", regs.busy, 1'b0);
        chk("rstmid_strobes", {regs.reg_wr_en, regs.reg_rd_en}, 2'b00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        i2c_stop();
        sb_empty("rstmid");

        i2c_start();
        write_byte(8'h90, a);
        chk("post_rst_addr_ack", a, I2C_ACK);
        write_byte(8'h07, a);
        push(1'b1, 8'h07, 8'h99);
        write_byte(8'h99, a);
        chk("post_rst_data_ack", a, I2C_ACK);
        i2c_stop();
        chk("post_rst_ptr", regs.reg_addr, 8'h08);
        sb_empty("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
